mem_stage: RTL and testbench



---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_align.sv | 65 ++++++
 rtl/mem_stage.sv | 207 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage.
// - funct3 encodings for load/store access size and sign.
// - FSM state type for the dmem handshake.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane alignment for the memory stage.
// Ports:
//   i_addr_lo    - low two address bits (byte offset within the word)
//   i_funct3     - access size/sign
//   i_store_data - rs2 value, unshifted
//   i_rdata      - raw word returned by dmem
//   o_mask       - active byte lanes (0 for an unrecognised funct3)
//   o_wdata      - store data shifted into its byte lanes
//   o_load_data  - extracted and sign/zero-extended load result
//   o_misaligned - halfword on an odd address or word on a non-multiple of 4
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_mask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);

    logic [4:0]  w_shamt;
    logic [31:0] w_rshift;

    assign w_shamt  = {i_addr_lo, 3'b000};
    assign o_wdata  = i_store_data << w_shamt;
    assign w_rshift = i_rdata >> w_shamt;

    always_comb begin
        o_mask       = 4'b0000;
        o_load_data  = w_rshift;
        o_misaligned = 1'b0;
        case (i_funct3)
            F3_B: begin
                o_mask      = 4'b0001 << i_addr_lo;
                o_load_data = {{24{w_rshift[7]}}, w_rshift[7:0]};
            end
            F3_BU: begin
                o_mask      = 4'b0001 << i_addr_lo;
                o_load_data = {24'd0, w_rshift[7:0]};
            end
            F3_H: begin
                o_mask       = 4'b0011 << i_addr_lo;
                o_load_data  = {{16{w_rshift[15]}}, w_rshift[15:0]};
                o_misaligned = i_addr_lo[0];
            end
            F3_HU: begin
                o_mask       = 4'b0011 << i_addr_lo;
                o_load_data  = {16'd0, w_rshift[15:0]};
                o_misaligned = i_addr_lo[0];
            end
            F3_W: begin
                o_mask       = 4'b1111;
                o_load_data  = i_rdata;
                o_misaligned = |i_addr_lo;
            end
            default: begin
                o_mask = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage RV32I pipeline (between EX and WB).
// Drives the data-memory port from the EX/MEM bundle, waits on a
// variable-latency dmem (stalling upstream), and registers the MEM/WB bundle.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   i_valid .. i_reg_write     - EX/MEM bundle
//   o_stall                    - hold EX/MEM and earlier stages
//   o_dmem_*                   - request side of the data-memory port
//   i_dmem_rdata, i_dmem_valid - response side (valid may be tied high)
//   o_wb_*                     - registered MEM/WB bundle
// Parameter TIMEOUT: cycles allowed in WAIT before the access traps; 0 = never.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_store_data,
    input  logic [4:0]  i_rd,
    input  logic        i_reg_write,
    output logic        o_stall,
    output logic [31:0] o_dmem_addr,
    output logic        o_dmem_ren,
    output logic        o_dmem_wen,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_mask,
    input  logic [31:0] i_dmem_rdata,
    input  logic        i_dmem_valid,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic        o_wb_reg_write,
    output logic [31:0] o_wb_data,
    output logic        o_wb_trap
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ren;
    logic               r_wen;
    logic [4:0]         r_rd;
    logic               r_reg_write;
    logic [31:0]        r_addr;
    logic [1:0]         r_addr_lo;
    logic [2:0]         r_funct3;
    logic [3:0]         r_mask;
    logic [31:0]        r_wdata;

    logic               r_wb_valid;
    logic [4:0]         r_wb_rd;
    logic               r_wb_reg_write;
    logic [31:0]        r_wb_data;
    logic               r_wb_trap;

    logic               w_in_wait;
    logic [1:0]         w_addr_lo;
    logic [2:0]         w_funct3;
    logic [3:0]         w_mask;
    logic [31:0]        w_wdata;
    logic [31:0]        w_load_data;
    logic               w_misaligned;
    logic               w_f3_ok;
    logic               w_mem_op;
    logic               w_bad;
    logic               w_legal;
    logic               w_timeout;
    logic               w_enter_wait;

    // While waiting, alignment works on the latched offset/size so the
    // load result matches the request actually in flight.
    assign w_in_wait = (r_state == WAIT);
    assign w_addr_lo = w_in_wait ? r_addr_lo : i_alu_result[1:0];
    assign w_funct3  = w_in_wait ? r_funct3  : i_funct3;

    mem_align u_align (
        .i_addr_lo    (w_addr_lo),
        .i_funct3     (w_funct3),
        .i_store_data (i_store_data),
        .i_rdata      (i_dmem_rdata),
        .o_mask       (w_mask),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data),
        .o_misaligned (w_misaligned)
    );

    // Stores accept only b/h/w; loads additionally accept the unsigned forms.
    always_comb begin
        w_f3_ok = 1'b0;
        if (i_mem_write) begin
            w_f3_ok = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W);
        end else begin
            w_f3_ok = (i_funct3 == F3_B)  || (i_funct3 == F3_H) || (i_funct3 == F3_W) ||
                      (i_funct3 == F3_BU) || (i_funct3 == F3_HU);
        end
    end

    assign w_mem_op     = i_valid & (i_mem_read | i_mem_write);
    assign w_bad        = w_mem_op & ((i_mem_read & i_mem_write) | ~w_f3_ok | w_misaligned);
    assign w_legal      = w_mem_op & ~w_bad;
    assign w_timeout    = (TIMEOUT > 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_enter_wait = (r_state == IDLE) & w_legal & ~i_dmem_valid;

    // The timeout cycle releases the stall so the trap entry enters MEM/WB
    // on the same edge the FSM returns to IDLE.
    assign o_stall      = w_in_wait ? (~i_dmem_valid & ~w_timeout) : (w_legal & ~i_dmem_valid);
    assign o_dmem_addr  = w_in_wait ? r_addr  : {i_alu_result[31:2], 2'b00};
    assign o_dmem_ren   = w_in_wait ? r_ren   : (w_legal & i_mem_read);
    assign o_dmem_wen   = w_in_wait ? r_wen   : (w_legal & i_mem_write);
    assign o_dmem_mask  = w_in_wait ? r_mask  : (w_legal ? w_mask : 4'b0000);
    assign o_dmem_wdata = w_in_wait ? r_wdata : w_wdata;

    // Request payload latch; only meaningful while in WAIT, so no reset.
    always_ff @(posedge clk) begin
        if (w_enter_wait) begin
            r_addr    <= {i_alu_result[31:2], 2'b00};
            r_addr_lo <= i_alu_result[1:0];
            r_funct3  <= i_funct3;
            r_mask    <= w_mask;
            r_wdata   <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_ren          <= 1'b0;
            r_wen          <= 1'b0;
            r_rd           <= 5'd0;
            r_reg_write    <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= 5'd0;
            r_wb_reg_write <= 1'b0;
            r_wb_data      <= 32'd0;
            r_wb_trap      <= 1'b0;
        end else begin
            // Default: bubble into MEM/WB unless an instruction retires below.
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= 5'd0;
            r_wb_reg_write <= 1'b0;
            r_wb_data      <= 32'd0;
            r_wb_trap      <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_enter_wait) begin
                        r_state     <= WAIT;
                        r_ren       <= i_mem_read;
                        r_wen       <= i_mem_write;
                        r_rd        <= i_rd;
                        r_reg_write <= i_mem_read & i_reg_write & (i_rd != 5'd0);
                    end else if (i_valid) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= i_rd;
                        if (w_bad) begin
                            r_wb_trap <= 1'b1;
                        end else if (w_mem_op && i_mem_read) begin
                            r_wb_data      <= w_load_data;
                            r_wb_reg_write <= i_reg_write & (i_rd != 5'd0);
                        end else if (!w_mem_op) begin
                            r_wb_data      <= i_alu_result;
                            r_wb_reg_write <= i_reg_write & (i_rd != 5'd0);
                        end
                    end
                end
                WAIT: begin
                    if (i_dmem_valid) begin
                        r_state        <= IDLE;
                        r_cnt          <= '0;
                        r_ren          <= 1'b0;
                        r_wen          <= 1'b0;
                        r_wb_valid     <= 1'b1;
                        r_wb_rd        <= r_rd;
                        r_wb_reg_write <= r_reg_write;
                        r_wb_data      <= r_ren ? w_load_data : 32'd0;
                    end else if (w_timeout) begin
                        r_state    <= IDLE;
                        r_cnt      <= '0;
                        r_ren      <= 1'b0;
                        r_wen      <= 1'b0;
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_trap  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_wb_valid     = r_wb_valid;
    assign o_wb_rd        = r_wb_rd;
    assign o_wb_reg_write = r_wb_reg_write;
    assign o_wb_data      = r_wb_data;
    assign o_wb_trap      = r_wb_trap;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage (TIMEOUT=4).
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [2:0]  i_funct3;
    logic [31:0] i_alu_result;
    logic [31:0] i_store_data;
    logic [4:0]  i_rd;
    logic        i_reg_write;
    logic        o_stall;
    logic [31:0] o_dmem_addr;
    logic        o_dmem_ren;
    logic        o_dmem_wen;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_mask;
    logic [31:0] i_dmem_rdata;
    logic        i_dmem_valid;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic        o_wb_reg_write;
    logic [31:0] o_wb_data;
    logic        o_wb_trap;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_valid        (i_valid),
        .i_mem_read     (i_mem_read),
        .i_mem_write    (i_mem_write),
        .i_funct3       (i_funct3),
        .i_alu_result   (i_alu_result),
        .i_store_data   (i_store_data),
        .i_rd           (i_rd),
        .i_reg_write    (i_reg_write),
        .o_stall        (o_stall),
        .o_dmem_addr    (o_dmem_addr),
        .o_dmem_ren     (o_dmem_ren),
        .o_dmem_wen     (o_dmem_wen),
        .o_dmem_wdata   (o_dmem_wdata),
        .o_dmem_mask    (o_dmem_mask),
        .i_dmem_rdata   (i_dmem_rdata),
        .i_dmem_valid   (i_dmem_valid),
        .o_wb_valid     (o_wb_valid),
        .o_wb_rd        (o_wb_rd),
        .o_wb_reg_write (o_wb_reg_write),
        .o_wb_data      (o_wb_data),
        .o_wb_trap      (o_wb_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one EX/MEM bundle plus dmem response, then settle.
    task automatic drive(input logic v, input logic rd_en, input logic wr_en,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] sdata, input logic [4:0] rd,
                         input logic regw, input logic [31:0] rdata, input logic dv);
        i_valid      = v;
        i_mem_read   = rd_en;
        i_mem_write  = wr_en;
        i_funct3     = f3;
        i_alu_result = alu;
        i_store_data = sdata;
        i_rd         = rd;
        i_reg_write  = regw;
        i_dmem_rdata = rdata;
        i_dmem_valid = dv;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 3'b000, 32'd0, 32'd0, 5'd0, 0, 32'd0, 0);
        tick();
        tick();
        chk("rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
        chk("rst_wb_data", o_wb_data, 32'd0);
        chk("rst_wb_trap", {31'd0, o_wb_trap}, 32'd0);
        chk("rst_wb_regw", {31'd0, o_wb_reg_write}, 32'd0);
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        rst_n = 1'b1;
        tick();

        // sb 0xAB to 0x1003
        drive(1, 0, 1, F3_B, 32'h0000_1003, 32'h0000_00AB, 5'd7, 1, 32'd0, 1);
        chk("sb_addr", o_dmem_addr, 32'h0000_1000);
        chk("sb_mask", {28'd0, o_dmem_mask}, 32'h8);
        chk("sb_wdata", o_dmem_wdata, 32'hAB00_0000);
        chk("sb_wen", {31'd0, o_dmem_wen}, 32'd1);
        chk("sb_ren", {31'd0, o_dmem_ren}, 32'd0);
        chk("sb_stall", {31'd0, o_stall}, 32'd0);
        tick();
        chk("sb_wb_valid", {31'd0, o_wb_valid}, 32'd1);
        chk("sb_wb_regw", {31'd0, o_wb_reg_write}, 32'd0);
        chk("sb_wb_trap", {31'd0, o_wb_trap}, 32'd0);

        // sh 0xBEEF to 0x0102 -> upper half lanes
        drive(1, 0, 1, F3_H, 32'h0000_0102, 32'h1234_BEEF, 5'd0, 0, 32'd0, 1);
        chk("sh_mask", {28'd0, o_dmem_mask}, 32'hC);
        chk("sh_wdata", o_dmem_wdata, 32'hBEEF_0000);
        tick();

        // lh / lhu from 0x2002, rdata upper half 0x8001
        drive(1, 1, 0, F3_H, 32'h0000_2002, 32'd0, 5'd5, 1, 32'h8001_1234, 1);
        chk("lh_addr", o_dmem_addr, 32'h0000_2000);
        chk("lh_mask", {28'd0, o_dmem_mask}, 32'hC);
        chk("lh_ren", {31'd0, o_dmem_ren}, 32'd1);
        tick();
        chk("lh_wb_data", o_wb_data, 32'hFFFF_8001);
        chk("lh_wb_rd", {27'd0, o_wb_rd}, 32'd5);
        chk("lh_wb_regw", {31'd0, o_wb_reg_write}, 32'd1);
        drive(1, 1, 0, F3_HU, 32'h0000_2002, 32'd0, 5'd5, 1, 32'h8001_1234, 1);
        tick();
        chk("lhu_wb_data", o_wb_data, 32'h0000_8001);

        // lb / lbu from byte 1
        drive(1, 1, 0, F3_B, 32'h0000_5001, 32'd0, 5'd9, 1, 32'h0000_8000, 1);
        tick();
        chk("lb_wb_data", o_wb_data, 32'hFFFF_FF80);
        drive(1, 1, 0, F3_BU, 32'h0000_5001, 32'd0, 5'd9, 1, 32'h0000_8000, 1);
        tick();
        chk("lbu_wb_data", o_wb_data, 32'h0000_0080);

        // misaligned lw
        drive(1, 1, 0, F3_W, 32'h0000_3001, 32'd0, 5'd6, 1, 32'd0, 1);
        chk("mis_ren", {31'd0, o_dmem_ren}, 32'd0);
        chk("mis_wen", {31'd0, o_dmem_wen}, 32'd0);
        chk("mis_stall", {31'd0, o_stall}, 32'd0);
        tick();
        chk("mis_wb_valid", {31'd0, o_wb_valid}, 32'd1);
        chk("mis_wb_trap", {31'd0, o_wb_trap}, 32'd1);
        chk("mis_wb_regw", {31'd0, o_wb_reg_write}, 32'd0);

        // store with load-only funct3 (100) is illegal
        drive(1, 0, 1, F3_BU, 32'h0000_0010, 32'd1, 5'd0, 0, 32'd0, 1);
        chk("illf3_wen", {31'd0, o_dmem_wen}, 32'd0);
        tick();
        chk("illf3_wb_trap", {31'd0, o_wb_trap}, 32'd1);

        // read and write together is illegal
        drive(1, 1, 1, F3_W, 32'h0000_0020, 32'd1, 5'd4, 1, 32'd0, 1);
        chk("both_ren", {31'd0, o_dmem_ren}, 32'd0);
        chk("both_wen", {31'd0, o_dmem_wen}, 32'd0);
        tick();
        chk("both_wb_trap", {31'd0, o_wb_trap}, 32'd1);

        // lw 0x4000 with 3 cycles of wait, then data
        drive(1, 1, 0, F3_W, 32'h0000_4000, 32'd0, 5'd8, 1, 32'd0, 0);
        chk("wait_stall0", {31'd0, o_stall}, 32'd1);
        chk("wait_ren0", {31'd0, o_dmem_ren}, 32'd1);
        tick();
        // upstream input changes must not disturb the latched request
        drive(1, 1, 0, F3_W, 32'h0000_0000, 32'd0, 5'd8, 1, 32'd0, 0);
        chk("wait_stall1", {31'd0, o_stall}, 32'd1);
        chk("wait_addr1", o_dmem_addr, 32'h0000_4000);
        chk("wait_ren1", {31'd0, o_dmem_ren}, 32'd1);
        chk("wait_wb_bubble1", {31'd0, o_wb_valid}, 32'd0);
        tick();
        chk("wait_stall2", {31'd0, o_stall}, 32'd1);
        chk("wait_addr2", o_dmem_addr, 32'h0000_4000);
        chk("wait_wb_bubble2", {31'd0, o_wb_valid}, 32'd0);
        tick();
        drive(1, 1, 0, F3_W, 32'h0000_0000, 32'd0, 5'd8, 1, 32'h1234_5678, 1);
        chk("wait_done_stall", {31'd0, o_stall}, 32'd0);
        tick();
        chk("wait_wb_valid", {31'd0, o_wb_valid}, 32'd1);
        chk("wait_wb_data", o_wb_data, 32'h1234_5678);
        chk("wait_wb_rd", {27'd0, o_wb_rd}, 32'd8);
        chk("wait_wb_regw", {31'd0, o_wb_reg_write}, 32'd1);

        // timeout: valid never arrives
        drive(1, 1, 0, F3_W, 32'h0000_6000, 32'd0, 5'd2, 1, 32'd0, 0);
        chk("to_stall_a", {31'd0, o_stall}, 32'd1);
        tick();
        chk("to_stall_b", {31'd0, o_stall}, 32'd1);
        tick();
        chk("to_stall_c", {31'd0, o_stall}, 32'd1);
        tick();
        chk("to_stall_d", {31'd0, o_stall}, 32'd1);
        chk("to_bubble_d", {31'd0, o_wb_valid}, 32'd0);
        tick();
        chk("to_release", {31'd0, o_stall}, 32'd0);
        tick();
        chk("to_wb_valid", {31'd0, o_wb_valid}, 32'd1);
        chk("to_wb_trap", {31'd0, o_wb_trap}, 32'd1);
        chk("to_wb_regw", {31'd0, o_wb_reg_write}, 32'd0);
        drive(0, 0, 0, 3'b000, 32'd0, 32'd0, 5'd0, 0, 32'd0, 0);
        chk("to_dropped_ren", {31'd0, o_dmem_ren}, 32'd0);
        tick();
        chk("bubble_wb_valid", {31'd0, o_wb_valid}, 32'd0);

        // reset pulsed while waiting
        drive(1, 1, 0, F3_W, 32'h0000_7000, 32'd0, 5'd3, 1, 32'd0, 0);
        tick();
        chk("rw_stall_before", {31'd0, o_stall}, 32'd1);
        drive(0, 0, 0, 3'b000, 32'd0, 32'd0, 5'd0, 0, 32'd0, 0);
        rst_n = 1'b0;
        #1;
        chk("rw_stall", {31'd0, o_stall}, 32'd0);
        chk("rw_ren", {31'd0, o_dmem_ren}, 32'd0);
        chk("rw_wb_valid", {31'd0, o_wb_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rw_wb_after", {31'd0, o_wb_valid}, 32'd0);

        // addi passthrough to x0, dmem valid low must not stall
        drive(1, 0, 0, 3'b000, 32'hDEAD_BEEF, 32'd0, 5'd0, 1, 32'd0, 0);
        chk("addi_ren", {31'd0, o_dmem_ren}, 32'd0);
        chk("addi_wen", {31'd0, o_dmem_wen}, 32'd0);
        chk("addi_stall", {31'd0, o_stall}, 32'd0);
        tick();
        chk("addi_wb_data", o_wb_data, 32'hDEAD_BEEF);
        chk("addi_wb_regw", {31'd0, o_wb_reg_write}, 32'd0);
        chk("addi_wb_valid", {31'd0, o_wb_valid}, 32'd1);
        drive(1, 0, 0, 3'b000, 32'h0000_0042, 32'd0, 5'd3, 1, 32'd0, 0);
        tick();
        chk("alu_wb_data", o_wb_data, 32'h0000_0042);
        chk("alu_wb_regw", {31'd0, o_wb_reg_write}, 32'd1);
        chk("alu_wb_rd", {27'd0, o_wb_rd}, 32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
